truth_table_scan: RTL and testbench

Sequential exhaustive evaluator for a parametrised N-input logic function, generalising the fixed 3-input gate s = a & (b | c). On `start` it sweeps every input vector 0..2^N-1, one per clock, captures each result into a 2^N-bit truth-table register, and counts the true minterms. It sits beside the lab's combinational gate modules as a self-checking sweep engine, replacing hand-written stimulus sequences.

---
 rtl/truth_table_pkg.sv | 24 ++
 rtl/truth_table_scan_func_eval.sv | 31 +++
 rtl/truth_table_scan.sv | 98 +++++++++
 tb/tb_truth_table_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweep engine.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_AND_OR  = 2'd0,
    MODE_NAND_OR = 2'd1,
    MODE_OR_AND  = 2'd2,
    MODE_PARITY  = 2'd3
  } mode_t;

  localparam int N_MAX = 6;

  // Truth-table width for an n-input function.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_scan_func_eval.sv
// Combinational evaluator for the selectable N-input function, x[N-1] is the "a" input.
module tt_func_eval
  import truth_table_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] x,
  input  logic [1:0]   mode,
  output logic         f
);

  logic a;
  logic lo_or;
  logic lo_and;

  assign a      = x[N-1];
  assign lo_or  = |x[N-2:0];
  assign lo_and = &x[N-2:0];

  always_comb begin
    f = 1'b0;
    case (mode_t'(mode))
      MODE_AND_OR:  f = a & lo_or;
      MODE_NAND_OR: f = ~(a & lo_or);
      MODE_OR_AND:  f = a | lo_and;
      MODE_PARITY:  f = ^x;
      default:      f = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_table_scan.sv
// Exhaustive sweep of an N-input function into a 2^N-bit truth table.
// Define TRUTH_TABLE_SCAN_ONES_EN to build the minterm counter; otherwise ones reads 0.
module truth_table_scan
  import truth_table_pkg::*;
#(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       vec,
  output logic               s,
  output logic [(1<<N)-1:0]  tbl,
  output logic [N:0]         ones
);

  localparam int W = tt_width(N);

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [N-1:0]   vec_q, vec_d;
  logic [W-1:0]   tbl_q, tbl_d;
  logic           f;

  tt_func_eval #(.N(N)) u_eval (
    .x    (vec_q),
    .mode (mode_q),
    .f    (f)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          vec_d   = '0;
          tbl_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        tbl_d[vec_q] = f;
        // vec parks at the last vector once the sweep ends
        if (vec_q == {N{1'b1}}) state_d = DONE;
        else                    vec_d   = vec_q + N'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_AND_OR;
      vec_q   <= '0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
    end
  end

`ifdef TRUTH_TABLE_SCAN_ONES_EN
  logic [N:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (state_q == IDLE && start)   ones_d = '0;
    else if (state_q == SCAN && f)  ones_d = ones_q + (N+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ones_q <= '0;
    else     ones_q <= ones_d;
  end

  assign ones = ones_q;
`else
  assign ones = '0;
`endif

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);
  assign vec  = vec_q;
  assign s    = f;
  assign tbl  = tbl_q;

endmodule

// File: tb/tb_truth_table_scan.sv
// Scoreboard bench: N=3 and N=6 instances, directed sweeps with hand-computed tables.
module tb_truth_table_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0, start6 = 1'b0;
  logic [1:0]  mode3 = 2'd0, mode6 = 2'd0;
  logic        busy3, done3, s3, busy6, done6, s6;
  logic [2:0]  vec3;
  logic [5:0]  vec6;
  logic [7:0]  tbl3;
  logic [63:0] tbl6;
  logic [3:0]  ones3;
  logic [6:0]  ones6;

  truth_table_scan #(.N(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .busy(busy3), .done(done3),
    .vec(vec3), .s(s3), .tbl(tbl3), .ones(ones3)
  );

  truth_table_scan #(.N(6)) u6 (
    .clk(clk), .rst(rst), .start(start6), .mode(mode6), .busy(busy6), .done(done6),
    .vec(vec6), .s(s6), .tbl(tbl6), .ones(ones6)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] tbl;
    int          ones;
    int          t0;
    int          lat;
    int          blen;
  } exp_t;

  exp_t q3[$];
  exp_t q6[$];
  exp_t e3, e6;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   bn3 = 0, bn6 = 0;
  bit   w3 = 0, w6 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic int eo(input int n);
`ifdef TRUTH_TABLE_SCAN_ONES_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Monitors: pop and compare whenever a done pulse appears.
  always @(negedge clk) begin
    if (rst) begin
      bn3 = 0; w3 = 0;
    end else begin
      if (w3) begin check("done3_width", {63'b0, done3}, 64'd0); w3 = 0; end
      if (busy3) bn3++;
      if (done3) begin
        if (q3.size() == 0) begin
          tot_cnt++;
          $display("FAIL done3_unexpected: got done pulse, required none");
        end else begin
          e3 = q3.pop_front();
          check("tbl3", tbl3, e3.tbl);
          check("ones3", ones3, e3.ones);
          check("lat3", cyc - e3.t0, e3.lat);
          check("busy3_len", bn3, e3.blen);
        end
        bn3 = 0; w3 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bn6 = 0; w6 = 0;
    end else begin
      if (w6) begin check("done6_width", {63'b0, done6}, 64'd0); w6 = 0; end
      if (busy6) bn6++;
      if (done6) begin
        if (q6.size() == 0) begin
          tot_cnt++;
          $display("FAIL done6_unexpected: got done pulse, required none");
        end else begin
          e6 = q6.pop_front();
          check("tbl6", tbl6, e6.tbl);
          check("ones6", ones6, e6.ones);
          check("lat6", cyc - e6.t0, e6.lat);
          check("busy6_len", bn6, e6.blen);
        end
        bn6 = 0; w6 = 1;
      end
    end
  end

  task automatic launch(input bit big, input logic [1:0] m, input logic [63:0] et, input int on);
    exp_t e;
    @(posedge clk); #1;
    e.tbl = et; e.ones = eo(on); e.t0 = cyc;
    e.lat = big ? 65 : 9; e.blen = big ? 64 : 8;
    if (big) begin q6.push_back(e); mode6 = m; start6 = 1'b1; end
    else     begin q3.push_back(e); mode3 = m; start3 = 1'b1; end
    @(posedge clk); #1;
    start3 = 1'b0; start6 = 1'b0;
  endtask

  task automatic wait_done(input bit big);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (big ? done6 : done3) break;
    end
    if (k == 200) begin
      tot_cnt++;
      $display("FAIL wait_done: got no done in 200 cycles, required done");
    end
    @(negedge clk);
  endtask

  task automatic sweep(input bit big, input logic [1:0] m, input logic [63:0] et, input int on);
    launch(big, m, et, on);
    wait_done(big);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", vec3, 0);
    check("rst_tbl", tbl3, 0);
    check("rst_ones", ones3, 0);
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    rst = 1'b0;

    sweep(0, 2'd0, 64'hE0, 3);
    sweep(0, 2'd1, 64'h1F, 5);
    sweep(0, 2'd2, 64'hF8, 5);
    sweep(0, 2'd3, 64'h96, 4);

    // start and mode change mid-scan must be ignored
    launch(0, 2'd0, 64'hE0, 3);
    repeat (3) @(posedge clk);
    #1; mode3 = 2'd3; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    wait_done(0);
    repeat (12) @(negedge clk);

    // abort a mode-1 sweep at vec=4, where the partial table is nonzero
    @(posedge clk); #1; mode3 = 2'd1; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy3 && vec3 == 3'd4) break;
    end
    check("abort_reached_vec4", vec3, 4);
    #1 rst = 1'b1;
    #1;
    check("abort_vec", vec3, 0);
    check("abort_tbl", tbl3, 0);
    check("abort_ones", ones3, 0);
    check("abort_busy", busy3, 0);
    check("abort_done", done3, 0);
    check("abort_s_mode0", s3, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sweep(0, 2'd0, 64'hE0, 3);

    sweep(1, 2'd3, 64'h6996966996696996, 32);
    sweep(1, 2'd0, 64'hFFFFFFFE00000000, 31);

    repeat (10) @(negedge clk);
    check("q3_drained", q3.size(), 0);
    check("q6_drained", q6.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
